// File: rtl/button_event_counter.sv
// Multi-channel button front end: synchronizes and debounces raw button
// levels, produces press/release/auto-repeat pulses per channel, and drives
// an up/down counter from channel 0 (up) and channel 1 (down).
module button_event_counter #(
  parameter int NUM_BTN         = 7,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int CNT_WIDTH       = 8,
  parameter int SATURATE        = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_BTN-1:0]   btn_in_i,
  output logic [NUM_BTN-1:0]   btn_db_o,
  output logic [NUM_BTN-1:0]   press_o,
  output logic [NUM_BTN-1:0]   release_o,
  output logic [NUM_BTN-1:0]   repeat_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam int DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TimeMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TimerW  = $clog2(TimeMax + 1);

  localparam logic [DbW-1:0]    DB_LAST     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TimerW-1:0] DELAY_LAST  = TimerW'(REPEAT_DELAY - 1);
  localparam logic [TimerW-1:0] PERIOD_LAST = TimerW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rptState_e;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] pressVec;
  logic [NUM_BTN-1:0] repeatVec;
  logic [CNT_WIDTH-1:0] count_q;
  logic up;
  logic down;

  // Two-flop synchronizer bringing the asynchronous button levels into clk_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < NUM_BTN; ch++) begin : gChan
    logic [DbW-1:0]    dbCnt_q;
    logic [DbW-1:0]    dbCnt_d;
    logic              db_q;
    logic              db_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;
    logic              repeat_q;
    logic [TimerW-1:0] timer_q;
    rptState_e         state_q;

    // Debounce: count consecutive disagreeing samples, accept the new level
    // once it has disagreed for the full window, and flag the edge direction
    always_comb begin
      dbCnt_d   = '0;
      db_d      = db_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q[ch] != db_q) begin
        if (dbCnt_q == DB_LAST) begin
          db_d      = sync2_q[ch];
          press_d   = sync2_q[ch];
          release_d = ~sync2_q[ch];
        end else begin
          dbCnt_d = dbCnt_q + 1'b1;
        end
      end
    end

    // Register the debounced level and its edge pulses together so the pulse
    // lines up with the cycle the new level becomes visible
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dbCnt_q   <= '0;
        db_q      <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        dbCnt_q   <= dbCnt_d;
        db_q      <= db_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Auto-repeat FSM; looks at the next debounced level so a repeat can
    // never be emitted in the same cycle the button is seen released
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        if (!db_d) begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (press_d) begin
                state_q <= ST_DELAY;
                timer_q <= '0;
              end
            end
            ST_DELAY: begin
              if (timer_q == DELAY_LAST) begin
                repeat_q <= 1'b1;
                timer_q  <= '0;
                state_q  <= ST_REPEAT;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (timer_q == PERIOD_LAST) begin
                repeat_q <= 1'b1;
                timer_q  <= '0;
              end else begin
                timer_q <= timer_q + 1'b1;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          endcase
        end
      end
    end

    assign btn_db_o[ch]  = db_q;
    assign press_o[ch]   = press_q;
    assign release_o[ch] = release_q;
    assign repeat_o[ch]  = repeat_q;
    assign pressVec[ch]  = press_q;
    assign repeatVec[ch] = repeat_q;
  end

  assign up   = pressVec[0] | repeatVec[0];
  assign down = pressVec[1] | repeatVec[1];

  // Up/down counter; opposing events cancel, ends either wrap or clamp
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (up && !down) begin
      if ((count_q != '1) || (SATURATE == 0)) begin
        count_q <= count_q + 1'b1;
      end
    end else if (down && !up) begin
      if ((count_q != '0) || (SATURATE == 0)) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_button_event_counter.sv
// Self-checking bench for button_event_counter with short timing parameters.
// A wrapping and a clamping instance share the same stimulus.
module tb_button_event_counter;

  localparam int NB = 7;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btnIn;
  logic [NB-1:0] btnDb, press, rel, rpt;
  logic [CW-1:0] cnt;
  logic [NB-1:0] satDb, satPress, satRel, satRpt;
  logic [CW-1:0] satCnt;

  int checks = 0;
  int errors = 0;
  int expCnt = 0;
  int expSat = 0;

  typedef struct {
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] db;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[16];

  button_event_counter #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .CNT_WIDTH(CW), .SATURATE(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .btn_in_i(btnIn), .btn_db_o(btnDb),
    .press_o(press), .release_o(rel), .repeat_o(rpt), .count_o(cnt)
  );

  button_event_counter #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .CNT_WIDTH(CW), .SATURATE(1)
  ) dutSat (
    .clk_i(clk), .rst_i(rst), .btn_in_i(btnIn), .btn_db_o(satDb),
    .press_o(satPress), .release_o(satRel), .repeat_o(satRpt), .count_o(satCnt)
  );

  always #5 clk = ~clk;

  // Drive inputs, advance one rising edge, then settle before sampling
  task automatic applyStimulus(input logic r, input logic [NB-1:0] b);
    rst   = r;
    btnIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference counter behaviour for both the wrapping and clamping variants
  task automatic modelEvent(input logic u, input logic d);
    if (u && !d) begin
      expCnt = (expCnt + 1) % 16;
      if (expSat < 15) expSat++;
    end else if (d && !u) begin
      expCnt = (expCnt + 15) % 16;
      if (expSat > 0) expSat--;
    end
  endtask

  // Short press-and-release on the channels in mask; held too briefly to repeat
  task automatic tapButton(input logic [NB-1:0] mask);
    logic [NB-1:0] expP;
    for (int e = 1; e <= 18; e++) begin
      applyStimulus(1'b0, (e <= 9) ? mask : '0);
      expP = (e == 6) ? mask : '0;
      checkOutput($sformatf("tap%0h_press_e%0d", mask, e), 32'(press), 32'(expP));
      if (e == 6) begin
        checkOutput($sformatf("tap%0h_db_rise", mask), 32'(btnDb), 32'(mask));
        modelEvent(mask[0], mask[1]);
      end
      if (e == 7) begin
        checkOutput($sformatf("tap%0h_cnt", mask), 32'(cnt), 32'(expCnt));
        checkOutput($sformatf("tap%0h_satcnt", mask), 32'(satCnt), 32'(expSat));
      end
      if (e == 15) begin
        checkOutput($sformatf("tap%0h_release", mask), 32'(rel), 32'(mask));
        checkOutput($sformatf("tap%0h_db_fall", mask), 32'(btnDb), 32'd0);
        checkOutput($sformatf("tap%0h_norepeat", mask), 32'(rpt), 32'd0);
      end
    end
  endtask

  initial begin
    logic [NB-1:0] allOn;
    logic eDb, eP, eR, eRep;
    allOn = '1;
    rst   = 1'b1;
    btnIn = '0;

    // Reset held with all buttons down, then requalification and release
    vecs[0] = '{1'b1, allOn, '0, '0, '0, '0, '0};
    vecs[1] = '{1'b1, allOn, '0, '0, '0, '0, '0};
    for (int k = 2; k <= 6; k++) vecs[k] = '{1'b0, allOn, '0, '0, '0, '0, '0};
    vecs[7] = '{1'b0, allOn, allOn, allOn, '0, '0, '0};
    vecs[8] = '{1'b0, allOn, allOn, '0, '0, '0, '0};
    for (int k = 9; k <= 13; k++) vecs[k] = '{1'b0, '0, allOn, '0, '0, '0, '0};
    vecs[14] = '{1'b0, '0, '0, '0, allOn, '0, '0};
    vecs[15] = '{1'b0, '0, '0, '0, '0, '0, '0};

    for (int k = 0; k < 16; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].btn);
      checkOutput($sformatf("vec%0d_db", k), 32'(btnDb), 32'(vecs[k].db));
      checkOutput($sformatf("vec%0d_press", k), 32'(press), 32'(vecs[k].press));
      checkOutput($sformatf("vec%0d_release", k), 32'(rel), 32'(vecs[k].rel));
      checkOutput($sformatf("vec%0d_repeat", k), 32'(rpt), 32'(vecs[k].rpt));
      checkOutput($sformatf("vec%0d_cnt", k), 32'(cnt), 32'(vecs[k].cnt));
      checkOutput($sformatf("vec%0d_satcnt", k), 32'(satCnt), 32'(vecs[k].cnt));
    end

    // Bounce on channel 0: 3-cycle pulses must never be accepted
    for (int b = 0; b < 12; b++) begin
      applyStimulus(1'b0, ((b / 3) % 2 == 0) ? NB'(1) : NB'(0));
      checkOutput($sformatf("bounce%0d_db", b), 32'(btnDb[0]), 32'd0);
      checkOutput($sformatf("bounce%0d_press", b), 32'(press[0]), 32'd0);
    end

    // Final rise held for 30 cycles past the press, then released
    for (int i = 1; i <= 46; i++) begin
      applyStimulus(1'b0, (i <= 36) ? NB'(1) : NB'(0));
      eDb  = (i >= 6) && (i <= 41);
      eP   = (i == 6);
      eR   = (i == 42);
      eRep = (i >= 16) && (i <= 41) && ((i - 16) % 3 == 0);
      checkOutput($sformatf("hold%0d_db", i), 32'(btnDb[0]), 32'(eDb));
      checkOutput($sformatf("hold%0d_press", i), 32'(press[0]), 32'(eP));
      checkOutput($sformatf("hold%0d_release", i), 32'(rel[0]), 32'(eR));
      checkOutput($sformatf("hold%0d_repeat", i), 32'(rpt[0]), 32'(eRep));
      checkOutput($sformatf("hold%0d_cnt", i), 32'(cnt), 32'(expCnt));
      checkOutput($sformatf("hold%0d_satcnt", i), 32'(satCnt), 32'(expSat));
      modelEvent(eP | eRep, 1'b0);
    end
    checkOutput("hold_total_cnt", 32'(cnt), 32'd10);

    // Walk up to the top, then exercise wrap versus clamp at both ends
    for (int t = 0; t < 5; t++) tapButton(NB'(1));
    checkOutput("top_cnt", 32'(cnt), 32'd15);
    checkOutput("top_satcnt", 32'(satCnt), 32'd15);
    tapButton(NB'(1));
    checkOutput("wrap_up_cnt", 32'(cnt), 32'd0);
    checkOutput("clamp_up_satcnt", 32'(satCnt), 32'd15);
    tapButton(NB'(2));
    checkOutput("wrap_down_cnt", 32'(cnt), 32'd15);
    checkOutput("down_satcnt", 32'(satCnt), 32'd14);
    for (int t = 0; t < 14; t++) tapButton(NB'(2));
    checkOutput("bottom_satcnt", 32'(satCnt), 32'd0);
    checkOutput("bottom_cnt", 32'(cnt), 32'd1);
    tapButton(NB'(2));
    checkOutput("clamp_down_satcnt", 32'(satCnt), 32'd0);
    checkOutput("down_to_zero_cnt", 32'(cnt), 32'd0);

    // Channel 2 alone and simultaneous up/down leave the count untouched
    tapButton(NB'(4));
    checkOutput("ch2_cnt", 32'(cnt), 32'd0);
    tapButton(NB'(3));
    checkOutput("simul_cnt", 32'(cnt), 32'd0);
    checkOutput("simul_satcnt", 32'(satCnt), 32'd0);

    // Reset while channel 0 is auto-repeating, button kept held throughout
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(1'b0, NB'(1));
      eP   = (i == 6);
      eRep = (i == 16);
      checkOutput($sformatf("mid%0d_repeat", i), 32'(rpt[0]), 32'(eRep));
      modelEvent(eP | eRep, 1'b0);
    end
    checkOutput("mid_precnt", 32'(cnt), 32'(expCnt));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, NB'(1));
      checkOutput($sformatf("midrst%0d_cnt", i), 32'(cnt), 32'd0);
      checkOutput($sformatf("midrst%0d_satcnt", i), 32'(satCnt), 32'd0);
      checkOutput($sformatf("midrst%0d_repeat", i), 32'(rpt), 32'd0);
      checkOutput($sformatf("midrst%0d_db", i), 32'(btnDb), 32'd0);
      checkOutput($sformatf("midrst%0d_press", i), 32'(press), 32'd0);
    end
    expCnt = 0;
    expSat = 0;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b0, NB'(1));
      eP   = (i == 6);
      eRep = (i == 16);
      checkOutput($sformatf("requal%0d_press", i), 32'(press[0]), 32'(eP));
      checkOutput($sformatf("requal%0d_repeat", i), 32'(rpt[0]), 32'(eRep));
      if (i == 5) checkOutput("requal_db_low", 32'(btnDb[0]), 32'd0);
      if (i == 7) checkOutput("requal_cnt", 32'(cnt), 32'd1);
    end
    for (int i = 1; i <= 10; i++) applyStimulus(1'b0, '0);
    checkOutput("final_db", 32'(btnDb), 32'd0);
    checkOutput("final_repeat", 32'(rpt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
